// File: rtl/axi_ahb_vga_pkg.sv
// Constants and state types shared by the VGA AXI4-to-AHB read and write bridges.
package axi_ahb_vga_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HSIZE_64      = 3'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [2:0] {
    WR_IDLE,
    WR_WGET,
    WR_ADDR,
    WR_DATA,
    WR_RESP
  } wr_state_e;

endpackage

// File: rtl/axi4_to_ahb_vga_wr.sv
// AXI4 write burst to AHB-Lite bridge: each AXI beat becomes one SINGLE write,
// one B response per burst; any AHB error is folded into bresp.
module axi4_to_ahb_vga_wr
  import axi_ahb_vga_pkg::*;
#(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ID_W-1:0]       awid,
  input  logic [ADDR_W-1:0]     awaddr,
  input  logic [7:0]            awlen,
  input  logic [2:0]            awsize,
  input  logic [1:0]            awburst,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  input  logic                  wlast,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [ID_W-1:0]       bid,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  output logic [ADDR_W-1:0]     ahb_haddr,
  output logic [2:0]            ahb_hburst,
  output logic [3:0]            ahb_hprot,
  output logic [2:0]            ahb_hsize,
  output logic [1:0]            ahb_htrans,
  output logic                  ahb_hwrite,
  output logic [DATA_W-1:0]     ahb_hwdata,
  output logic [DATA_W/8-1:0]   ahb_hwstrb,
  input  logic [DATA_W-1:0]     ahb_hrdata,
  input  logic                  ahb_hready,
  input  logic                  ahb_hresp
);

  localparam int STRB_W = DATA_W / 8;
  localparam logic [ADDR_W-1:0] BEAT_INC = ADDR_W'(STRB_W);

  wr_state_e           state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [STRB_W-1:0]   strb_q, strb_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic                fixed_q, fixed_d;
  logic                err_q, err_d;

  logic                awready_q, awready_d;
  logic                wready_q, wready_d;
  logic                bvalid_q, bvalid_d;
  logic [1:0]          bresp_q, bresp_d;
  logic [ID_W-1:0]     bid_q, bid_d;
  logic [1:0]          htrans_q, htrans_d;
  logic                hwrite_q, hwrite_d;
  logic [ADDR_W-1:0]   haddr_q, haddr_d;
  logic [DATA_W-1:0]   hwdata_q, hwdata_d;
  logic [STRB_W-1:0]   hwstrb_q, hwstrb_d;

  // Beat size is fixed at DATA_W and wlast is redundant with the beat counter.
  logic unused_inputs;
  assign unused_inputs = ^{awsize, wlast, ahb_hrdata};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    strb_d  = strb_q;
    id_d    = id_q;
    fixed_d = fixed_q;
    err_d   = err_q;

    case (state_q)
      WR_IDLE: begin
        if (awvalid) begin
          id_d    = awid;
          addr_d  = awaddr;
          cnt_d   = awlen;
          fixed_d = (awburst == BURST_FIXED);
          err_d   = 1'b0;
          state_d = WR_WGET;
        end
      end
      WR_WGET: begin
        if (wvalid) begin
          data_d  = wdata;
          strb_d  = wstrb;
          state_d = WR_ADDR;
        end
      end
      WR_ADDR: begin
        if (ahb_hready) state_d = WR_DATA;
      end
      WR_DATA: begin
        if (ahb_hresp) err_d = 1'b1;
        if (ahb_hready) begin
          if (cnt_q == 8'd0) begin
            state_d = WR_RESP;
          end else begin
            cnt_d   = cnt_q - 8'd1;
            addr_d  = fixed_q ? addr_q : addr_q + BEAT_INC;
            state_d = WR_WGET;
          end
        end
      end
      WR_RESP: begin
        if (bready) state_d = WR_IDLE;
      end
      default: state_d = WR_IDLE;
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    awready_d = (state_d == WR_IDLE);
    wready_d  = (state_d == WR_WGET);
    bvalid_d  = (state_d == WR_RESP);
    bid_d     = bvalid_d ? id_d : '0;
    bresp_d   = (bvalid_d && err_d) ? RESP_SLVERR : RESP_OKAY;
    htrans_d  = (state_d == WR_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    hwrite_d  = (state_d == WR_ADDR);
    haddr_d   = (state_d == WR_ADDR) ? addr_d : '0;
    hwdata_d  = (state_d == WR_DATA) ? data_d : '0;
    hwstrb_d  = (state_d == WR_DATA) ? strb_d : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= WR_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
      id_q      <= '0;
      fixed_q   <= 1'b0;
      err_q     <= 1'b0;
      awready_q <= 1'b1;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      bid_q     <= '0;
      htrans_q  <= HTRANS_IDLE;
      hwrite_q  <= 1'b0;
      haddr_q   <= '0;
      hwdata_q  <= '0;
      hwstrb_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      strb_q    <= strb_d;
      id_q      <= id_d;
      fixed_q   <= fixed_d;
      err_q     <= err_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      bid_q     <= bid_d;
      htrans_q  <= htrans_d;
      hwrite_q  <= hwrite_d;
      haddr_q   <= haddr_d;
      hwdata_q  <= hwdata_d;
      hwstrb_q  <= hwstrb_d;
    end
  end

  assign awready    = awready_q;
  assign wready     = wready_q;
  assign bvalid     = bvalid_q;
  assign bresp      = bresp_q;
  assign bid        = bid_q;
  assign ahb_htrans = htrans_q;
  assign ahb_hwrite = hwrite_q;
  assign ahb_haddr  = haddr_q;
  assign ahb_hwdata = hwdata_q;
  assign ahb_hwstrb = hwstrb_q;
  assign ahb_hburst = HBURST_SINGLE;
  assign ahb_hprot  = 4'b0000;
  assign ahb_hsize  = HSIZE_64;

endmodule

// File: tb/tb_axi4_to_ahb_vga_wr.sv
// Randomised bench for axi4_to_ahb_vga_wr: a transfer-level model (expected AHB
// address/data/strobe queues and B responses) is checked every cycle.
`timescale 1ns/1ps
module tb_axi4_to_ahb_vga_wr;
  import axi_ahb_vga_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  awid = '0;
  logic [31:0] awaddr = '0;
  logic [7:0]  awlen = '0;
  logic [2:0]  awsize = '0;
  logic [1:0]  awburst = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [63:0] wdata = '0;
  logic [7:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [31:0] ahb_haddr;
  logic [2:0]  ahb_hburst;
  logic [3:0]  ahb_hprot;
  logic [2:0]  ahb_hsize;
  logic [1:0]  ahb_htrans;
  logic        ahb_hwrite;
  logic [63:0] ahb_hwdata;
  logic [7:0]  ahb_hwstrb;
  logic [63:0] ahb_hrdata = '0;
  logic        ahb_hready = 1'b1;
  logic        ahb_hresp = 1'b0;

  axi4_to_ahb_vga_wr #(.ID_W(4), .ADDR_W(32), .DATA_W(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .ahb_haddr(ahb_haddr), .ahb_hburst(ahb_hburst), .ahb_hprot(ahb_hprot),
    .ahb_hsize(ahb_hsize), .ahb_htrans(ahb_htrans), .ahb_hwrite(ahb_hwrite),
    .ahb_hwdata(ahb_hwdata), .ahb_hwstrb(ahb_hwstrb), .ahb_hrdata(ahb_hrdata),
    .ahb_hready(ahb_hready), .ahb_hresp(ahb_hresp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Expected transfers, in issue order.
  logic [31:0] exp_addr_q[$];
  logic [63:0] exp_data_q[$];
  logic [7:0]  exp_strb_q[$];
  logic [3:0]  exp_bid_q[$];
  logic [1:0]  exp_bresp_q[$];

  // Observed transfers of the current burst.
  logic [31:0] seen_addr[$];
  logic [63:0] seen_data[$];
  logic [7:0]  seen_strb[$];
  logic [3:0]  last_bid;
  logic [1:0]  last_bresp;

  logic [63:0] data_tab[16];
  logic [7:0]  strb_tab[16];

  bit mon_en = 0;
  bit in_data = 0;
  bit b_seen = 0;
  int data_beat = 0;
  int beat_cnt = 0;
  int err_beat = -1;
  int hr_mode = 0;
  int stall_cnt = 0;
  int aw_cyc = 0;
  int b_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // AHB slave responder and per-cycle compare against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n || !mon_en) begin
        ahb_hready = 1'b1;
        ahb_hresp  = 1'b0;
        in_data    = 0;
        stall_cnt  = 0;
      end else begin
        ahb_hresp = in_data && (data_beat == err_beat);
        case (hr_mode)
          0: ahb_hready = 1'b1;
          1: ahb_hready = ($urandom_range(0, 2) != 0);
          default: begin
            if (ahb_htrans == HTRANS_NONSEQ && stall_cnt < 2) begin
              ahb_hready = 1'b0;
              stall_cnt++;
            end else begin
              ahb_hready = 1'b1;
              if (ahb_htrans != HTRANS_NONSEQ) stall_cnt = 0;
            end
          end
        endcase

        chk("hburst", ahb_hburst, HBURST_SINGLE);
        chk("hsize", ahb_hsize, 3);
        chk("hprot", ahb_hprot, 0);
        chk("hwrite", ahb_hwrite, ahb_htrans == HTRANS_NONSEQ);
        chk("ready_excl", awready && wready, 0);

        if (in_data) begin
          chk("htrans_data", ahb_htrans, HTRANS_IDLE);
          if (exp_data_q.size() == 0) chk("data_no_exp", 1, 0);
          else begin
            chk("hwdata", ahb_hwdata, exp_data_q[0]);
            chk("hwstrb", ahb_hwstrb, exp_strb_q[0]);
          end
          if (ahb_hready) begin
            seen_data.push_back(ahb_hwdata);
            seen_strb.push_back(ahb_hwstrb);
            if (exp_data_q.size() != 0) begin
              void'(exp_data_q.pop_front());
              void'(exp_strb_q.pop_front());
            end
            in_data = 0;
          end
        end else if (ahb_htrans == HTRANS_NONSEQ) begin
          if (exp_addr_q.size() == 0) chk("spurious_nonseq", 1, 0);
          else chk("haddr", ahb_haddr, exp_addr_q[0]);
          if (ahb_hready) begin
            seen_addr.push_back(ahb_haddr);
            if (exp_addr_q.size() != 0) void'(exp_addr_q.pop_front());
            in_data   = 1;
            data_beat = beat_cnt;
            beat_cnt++;
          end
        end else begin
          chk("htrans_idle", ahb_htrans, HTRANS_IDLE);
        end

        if (bvalid) begin
          chk("awready_in_b", awready, 0);
          if (!b_seen) begin
            b_seen = 1;
            b_cyc  = cyc;
          end
          if (exp_bid_q.size() == 0) chk("spurious_b", 1, 0);
          else begin
            chk("bid", bid, exp_bid_q[0]);
            chk("bresp", bresp, exp_bresp_q[0]);
          end
          if (bready) begin
            last_bid   = bid;
            last_bresp = bresp;
            if (exp_bid_q.size() != 0) begin
              void'(exp_bid_q.pop_front());
              void'(exp_bresp_q.pop_front());
            end
          end
        end
      end
    end
  end

  task automatic push_model(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input int eb);
    logic [31:0] a;
    seen_addr.delete();
    seen_data.delete();
    seen_strb.delete();
    err_beat = eb;
    beat_cnt = 0;
    b_seen   = 0;
    for (int i = 0; i <= int'(len); i++) begin
      a = (burst == BURST_FIXED) ? addr : addr + 32'(8 * i);
      exp_addr_q.push_back(a);
      exp_data_q.push_back(data_tab[i]);
      exp_strb_q.push_back(strb_tab[i]);
    end
    exp_bid_q.push_back(id);
    exp_bresp_q.push_back((eb >= 0 && eb <= int'(len)) ? RESP_SLVERR : RESP_OKAY);
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst);
    int n = 0;
    awid = id; awaddr = addr; awlen = len; awburst = burst; awsize = 3'd3; awvalid = 1'b1;
    while (!awready && n < 100) begin @(posedge clk); #1; n++; end
    if (!awready) chk("aw_timeout", 1, 0);
    @(posedge clk); #1;
    aw_cyc  = cyc;
    awvalid = 1'b0;
    awaddr  = $urandom;
    awid    = 4'($urandom);
  endtask

  task automatic send_w(input int i, input int last, input int gap_max);
    int n;
    n = $urandom_range(0, gap_max);
    repeat (n) begin @(posedge clk); #1; end
    wdata = data_tab[i]; wstrb = strb_tab[i]; wlast = (i == last); wvalid = 1'b1;
    n = 0;
    while (!wready && n < 300) begin @(posedge clk); #1; n++; end
    if (!wready) chk("w_timeout", 1, 0);
    @(posedge clk); #1;
    wvalid = 1'b0;
    wdata  = {$urandom, $urandom};
    wstrb  = 8'($urandom);
  endtask

  task automatic recv_b(input int bdly);
    int n = 0;
    while (!bvalid && n < 300) begin @(posedge clk); #1; n++; end
    if (!bvalid) chk("b_timeout", 1, 0);
    repeat (bdly) begin @(posedge clk); #1; end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    @(negedge clk);
    chk("idle_after_b", awready, 1);
    chk("bvalid_drop", bvalid, 0);
  endtask

  task automatic do_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input int eb, input int bdly, input int gap_max);
    push_model(id, addr, len, burst, eb);
    send_aw(id, addr, len, burst);
    for (int i = 0; i <= int'(len); i++) send_w(i, int'(len), gap_max);
    recv_b(bdly);
  endtask

  task automatic fill_random(input int len);
    for (int i = 0; i <= len; i++) begin
      data_tab[i] = {$urandom, $urandom};
      strb_tab[i] = 8'($urandom);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_awready"}, awready, 1);
    chk({tag, "_wready"}, wready, 0);
    chk({tag, "_bvalid"}, bvalid, 0);
    chk({tag, "_bresp"}, bresp, 0);
    chk({tag, "_bid"}, bid, 0);
    chk({tag, "_htrans"}, ahb_htrans, 0);
    chk({tag, "_hwrite"}, ahb_hwrite, 0);
    chk({tag, "_haddr"}, ahb_haddr, 0);
    chk({tag, "_hwdata"}, ahb_hwdata, 0);
    chk({tag, "_hwstrb"}, ahb_hwstrb, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [7:0]  len;
    logic [31:0] addr;
    int n;

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk); #1 rst_n = 1'b1;
    mon_en = 1;

    // Single beat, zero wait states.
    hr_mode = 0;
    data_tab[0] = 64'hDEADBEEF_CAFEF00D;
    strb_tab[0] = 8'hFF;
    do_burst(4'h5, 32'h1000, 8'd0, BURST_INCR, -1, 0, 0);
    chk("single_addr", seen_addr[0], 32'h1000);
    chk("single_data", seen_data[0], 64'hDEADBEEF_CAFEF00D);
    chk("single_bid", last_bid, 4'h5);
    chk("single_bresp", last_bresp, 2'b00);
    chk("single_b_latency", b_cyc - aw_cyc, 3);

    // INCR 4 beats with two stall cycles in every address phase.
    hr_mode = 2;
    fill_random(3);
    do_burst(4'hA, 32'h2000, 8'd3, BURST_INCR, -1, 0, 0);
    chk("incr_addr1", seen_addr[1], 32'h2008);
    chk("incr_addr3", seen_addr[3], 32'h2018);
    chk("incr_beats", seen_data.size(), 4);

    // FIXED 3 beats with a directed strobe pattern.
    hr_mode = 0;
    fill_random(2);
    strb_tab[0] = 8'h0F; strb_tab[1] = 8'hF0; strb_tab[2] = 8'hFF;
    do_burst(4'h3, 32'h3000, 8'd2, BURST_FIXED, -1, 0, 0);
    chk("fixed_addr2", seen_addr[2], 32'h3000);
    chk("fixed_strb1", seen_strb[1], 8'hF0);

    // Error on beat 2 of 4, then a clean burst.
    fill_random(3);
    do_burst(4'h7, 32'h4000, 8'd3, BURST_INCR, 1, 0, 1);
    chk("err_bresp", last_bresp, 2'b10);
    chk("err_all_beats", seen_addr.size(), 4);
    fill_random(1);
    do_burst(4'h8, 32'h5000, 8'd1, BURST_INCR, -1, 0, 0);
    chk("clean_bresp", last_bresp, 2'b00);

    // WRAP as INCR, with five cycles of B backpressure.
    fill_random(1);
    do_burst(4'h9, 32'h6000, 8'd1, BURST_WRAP, -1, 5, 0);
    chk("wrap_addr1", seen_addr[1], 32'h6008);
    chk("bp_bid", last_bid, 4'h9);

    // Address wraps through zero.
    hr_mode = 1;
    fill_random(3);
    do_burst(4'hC, 32'hFFFF_FFF0, 8'd3, BURST_INCR, -1, 1, 1);
    chk("wrap0_addr2", seen_addr[2], 32'h0000_0000);

    // Randomised bursts.
    for (int t = 0; t < 25; t++) begin
      len  = 8'($urandom_range(0, 15));
      addr = $urandom;
      addr[2:0] = 3'b000;
      fill_random(int'(len));
      n = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 32'(len))) : -1;
      do_burst(4'($urandom), addr, len, 2'($urandom_range(0, 3)), n,
               int'($urandom_range(0, 3)), 2);
    end

    // Reset during the data phase of beat 2 of 4.
    hr_mode = 0;
    fill_random(3);
    push_model(4'h4, 32'h7000, 8'd3, BURST_INCR, -1);
    send_aw(4'h4, 32'h7000, 8'd3, BURST_INCR);
    send_w(0, 3, 0);
    send_w(1, 3, 0);
    n = 0;
    while (!(in_data && data_beat == 1) && n < 50) begin @(negedge clk); #1; n++; end
    chk("reach_data_beat2", in_data && data_beat == 1, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_htrans", ahb_htrans, 0);
    chk("mid_rst_wready", wready, 0);
    chk("mid_rst_bvalid", bvalid, 0);
    chk("mid_rst_awready", awready, 1);
    exp_addr_q.delete(); exp_data_q.delete(); exp_strb_q.delete();
    exp_bid_q.delete(); exp_bresp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    fill_random(0);
    do_burst(4'h6, 32'h8000, 8'd0, BURST_INCR, -1, 0, 0);
    chk("post_rst_bresp", last_bresp, 2'b00);
    chk("post_rst_bid", last_bid, 4'h6);
    chk("post_rst_addr", seen_addr[0], 32'h8000);
    chk("model_drained", exp_addr_q.size() + exp_bid_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi4_to_ahb_vga_wr.md
Name: axi4_to_ahb_vga_wr

Overview:
Write-direction companion to the VGA read bridge. Accepts one AXI4 write burst on the AW/W/B channels and issues it on AHB-Lite as a sequence of SINGLE 64-bit write transfers, one per AXI beat. It returns a single B response per burst and sits between the VGA frame-buffer writer (AXI4 master) and the AHB frame-buffer memory. Only one burst is outstanding at a time, with no address/data overlap across beats.

Parameters:
ID_W, 4, AXI ID width (awid/bid).
ADDR_W, 32, address width (AXI and AHB).
DATA_W, 64, data width. hsize = log2(DATA_W/8) = 3; beat address increment = DATA_W/8 = 8.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
awid  in  ID_W  write ID, latched and returned on bid
awaddr  in  ADDR_W  burst start address
awlen  in  8  beats minus 1
awsize  in  3  ignored; beat size fixed at DATA_W
awburst  in  2  00 FIXED, 01 INCR, 10 WRAP (treated as INCR)
awvalid  in  1  AW valid
awready  out  1  AW ready
wdata  in  DATA_W  write data
wstrb  in  DATA_W/8  byte strobes
wlast  in  1  ignored; the internal beat counter ends the burst
wvalid  in  1  W valid
wready  out  1  W ready
bid  out  ID_W  response ID
bresp  out  2  00 OKAY, 10 SLVERR
bvalid  out  1  B valid
bready  in  1  B ready
ahb_haddr  out  ADDR_W  AHB address
ahb_hburst  out  3  constant 000 (SINGLE)
ahb_hprot  out  4  constant 0000
ahb_hsize  out  3  constant 3
ahb_htrans  out  2  00 IDLE / 10 NONSEQ
ahb_hwrite  out  1  1 during the address phase, else 0
ahb_hwdata  out  DATA_W  write data, data phase
ahb_hwstrb  out  DATA_W/8  strobes, data phase (AHB5 style)
ahb_hrdata  in  DATA_W  unused
ahb_hready  in  1  transfer ready
ahb_hresp  in  1  1 = ERROR

Behaviour:
- States: IDLE, WGET, ADDR, DATA, RESP.
- Reset (async, any state):
  - state returns to IDLE; beat counter, address, data, strobe, ID and error registers clear to 0.
  - Outputs: awready=1, wready=0, bvalid=0, bresp=00, bid=0, htrans=00, hwrite=0, haddr=0, hwdata=0, hwstrb=0.
- IDLE:
  - awready=1.
  - On awvalid: latch awid, awaddr, awlen into the counter, awburst==00 into fixed_q; clear err_q; go to WGET.
- WGET:
  - wready=1.
  - On wvalid: latch wdata and wstrb into registers; go to ADDR.
- ADDR:
  - htrans=10, hwrite=1, haddr=addr_q.
  - Hold until hready=1, then go to DATA.
- DATA:
  - htrans=00, hwrite=0, hwdata=data_q, hwstrb=strb_q.
  - err_q sets on any cycle with hresp=1.
  - On hready=1, the beat completes:
    - If cnt_q==0, go to RESP.
    - Otherwise cnt_q-=1; addr_q+=8 unless fixed_q (wraps mod 2^ADDR_W); go to WGET.
- RESP:
  - bvalid=1, bid=id_q, bresp = err_q ? 10 : 00.
  - On bready, go to IDLE. bvalid/bid/bresp are held stable while bready=0.
- An AHB error does not abort the burst: all awlen+1 W beats are still consumed and written. The error is reported once, in bresp.
- Ready signals are pure state decodes: awready only in IDLE, wready only in WGET. The AW and W handshakes therefore never coincide, and a W beat presented early waits for WGET.
- Minimum throughput is 3 cycles per beat plus 1 AW cycle and 1 B cycle. Single-beat burst, zero wait states: AW handshake at cycle 0 → bvalid at cycle 4.
- hready=0 in ADDR or DATA stalls indefinitely with all outputs held.
- A WRAP burst is issued as INCR.

Decomposition:
- Shared package axi_ahb_vga_pkg, shared with the read bridge, holds:
  - HTRANS_IDLE/NONSEQ, HBURST_SINGLE, HSIZE_64, RESP_OKAY/SLVERR, BURST_FIXED/INCR/WRAP constants;
  - the write state enum typedef.
- No sub-module; a single flat module.

Test Plan:
- Single beat: awaddr=0x1000, awlen=0, wdata=0xDEADBEEF_CAFEF00D, wstrb=0xFF, hready=1 → one NONSEQ at 0x1000 with hwrite=1; hwdata is 0xDEADBEEF_CAFEF00D the next cycle; bvalid=1 at cycle 4 with bresp=00 and bid=awid.
- INCR 4-beat: awaddr=0x2000, awlen=3, hready low for 2 cycles in each ADDR phase → addresses 0x2000/0x2008/0x2010/0x2018; hwdata matches W beats in order; outputs held during stalls; one B response only.
- FIXED 3-beat: awburst=00, awaddr=0x3000 → all three NONSEQ at 0x3000; wstrb pattern 0x0F/0xF0/0xFF appears on hwstrb in each data phase.
- Error: 4-beat burst with hresp=1 on beat 2 → beats 3 and 4 still issued; bresp=10; the next burst with no error returns bresp=00.
- B backpressure: bready=0 for 5 cycles → bvalid/bid/bresp stable, awready=0 throughout; IDLE the cycle after bready=1.
- Reset mid-burst: assert rst_n=0 in DATA of beat 2 of 4 → htrans=00, wready=0, bvalid=0, awready=1 immediately. A fresh 1-beat burst afterwards completes with bresp=00.
